// File: rtl/dm_pkg.sv
// Shared debug-module package: DMI transaction types used between the
// debug transport side and the debug module's DMI port.
//   dtm_op_e        - DMI request opcode (NOP / READ / WRITE)
//   dtm_op_status_t - DMI response status (SUCCESS / ERR / BUSY)
//   dmi_req_t       - DMI request payload {addr[6:0], op, data[31:0]}
//   dmi_resp_t      - DMI response payload {data[31:0], resp[1:0]}
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'h0,
        DTM_ERR     = 2'h2,
        DTM_BUSY    = 2'h3
    } dtm_op_status_t;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    // The status field is kept as raw bits so that undefined codes can
    // arrive and be treated as errors.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dm_dmi_bridge.sv
// dm_dmi_bridge: word-bus slave that turns bus accesses into DMI
// request/response transactions towards the debug module.
//
// Ports
//   clk_i, rst_i               single clock, synchronous active-high reset
//   req_i/we_i/addr_i/be_i/wdata_i   bus request
//   gnt_o                      grant (combinational: req_i while idle)
//   r_valid_o/r_rdata_o/r_err_o      one-cycle bus response
//   dmi_req_valid_o/dmi_req_ready_i/dmi_req_o      DMI request channel
//   dmi_resp_valid_i/dmi_resp_ready_o/dmi_resp_i   DMI response channel
//   dmi_rst_no                 active-low one-cycle clear of the DMI
//                              response FIFO, pulsed on an attempt timeout
//
// Only one DMI transaction is in flight at a time; new bus requests are
// held off (no grant) until the current one has produced its response.
module dm_dmi_bridge
    import dm::*;
#(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned MaxRetries    = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   addr_i,
    input  logic [BusWidth/8-1:0] be_i,
    input  logic [BusWidth-1:0]   wdata_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  r_err_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output dm::dmi_req_t          dmi_req_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  dm::dmi_resp_t         dmi_resp_i,
    output logic                  dmi_rst_no
);

    localparam int unsigned TmoW   = $clog2(TimeoutCycles);
    localparam int unsigned RetryW = $clog2(MaxRetries + 1);
    localparam logic [TmoW-1:0]   TmoMax   = TmoW'(TimeoutCycles - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetries);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } state_e;

    // An access maps onto the 128-word DMI space: word aligned, below 0x200,
    // and writes must cover the full low 32-bit word.
    function automatic logic access_legal(
        input logic [BusWidth-1:0]   addr,
        input logic                  we,
        input logic [BusWidth/8-1:0] be
    );
        return (addr[1:0] == 2'b00) && !(|addr[BusWidth-1:9]) &&
               (!we || (be[3:0] == 4'hF));
    endfunction

    state_e                state_r, state_s;
    logic [TmoW-1:0]       tmo_r, tmo_s;
    logic [RetryW-1:0]     retry_r, retry_s;
    logic [BusWidth-1:0]   addr_r, addr_s;
    logic                  we_r, we_s;
    logic [BusWidth/8-1:0] be_r, be_s;
    logic [BusWidth-1:0]   wdata_r, wdata_s;
    logic [BusWidth-1:0]   rdata_r, rdata_s;
    logic                  err_r, err_s;
    logic                  tmo_hit_s;
    logic                  unused_s;

    // The current attempt has used up its cycle budget this cycle.
    assign tmo_hit_s = ((state_r == REQ) || (state_r == WAIT_RESP)) &&
                       (tmo_r == TmoMax);

    assign gnt_o            = req_i && (state_r == IDLE);
    assign r_valid_o        = (state_r == RESP);
    assign r_rdata_o        = rdata_r;
    assign r_err_o          = err_r;
    assign dmi_req_valid_o  = (state_r == REQ);
    assign dmi_resp_ready_o = (state_r == WAIT_RESP);
    assign dmi_rst_no       = !tmo_hit_s;

    // Byte enables and the address bits outside [8:2] are captured with the
    // access but never steer the DMI payload.
    assign unused_s = ^{be_r, addr_r, wdata_r};

    // DMI request payload, driven from the captured access so it stays
    // stable across stalls and busy retries.
    always_comb begin
        dmi_req_o.addr = addr_r[8:2];
        if (we_r) begin
            dmi_req_o.op   = DTM_WRITE;
            dmi_req_o.data = wdata_r[31:0];
        end else begin
            dmi_req_o.op   = DTM_READ;
            dmi_req_o.data = 32'h0000_0000;
        end
    end

    // Next-state, counter, capture and response logic.
    always_comb begin
        state_s = state_r;
        tmo_s   = tmo_r;
        retry_s = retry_r;
        addr_s  = addr_r;
        we_s    = we_r;
        be_s    = be_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                rdata_s = {BusWidth{1'b0}};
                err_s   = 1'b0;
                if (req_i) begin
                    addr_s  = addr_i;
                    we_s    = we_i;
                    be_s    = be_i;
                    wdata_s = wdata_i;
                    retry_s = {RetryW{1'b0}};
                    if (access_legal(addr_i, we_i, be_i)) begin
                        state_s = REQ;
                        tmo_s   = {TmoW{1'b0}};
                    end else begin
                        state_s = RESP;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // Timeout wins over a handshake in the same cycle.
                if (tmo_hit_s) begin
                    state_s = RESP;
                    err_s   = 1'b1;
                    rdata_s = {BusWidth{1'b0}};
                end else if (dmi_req_ready_i) begin
                    state_s = WAIT_RESP;
                    tmo_s   = tmo_r + 1'b1;
                end else begin
                    tmo_s   = tmo_r + 1'b1;
                end
            end
            WAIT_RESP: begin
                if (tmo_hit_s) begin
                    state_s = RESP;
                    err_s   = 1'b1;
                    rdata_s = {BusWidth{1'b0}};
                end else if (dmi_resp_valid_i) begin
                    case (dmi_resp_i.resp)
                        DTM_SUCCESS: begin
                            state_s = RESP;
                            err_s   = 1'b0;
                            if (we_r) begin
                                rdata_s = {BusWidth{1'b0}};
                            end else begin
                                rdata_s = BusWidth'(dmi_resp_i.data);
                            end
                        end
                        DTM_BUSY: begin
                            if (retry_r < RetryMax) begin
                                state_s = REQ;
                                retry_s = retry_r + 1'b1;
                                tmo_s   = {TmoW{1'b0}};
                            end else begin
                                state_s = RESP;
                                err_s   = 1'b1;
                                rdata_s = {BusWidth{1'b0}};
                            end
                        end
                        default: begin
                            state_s = RESP;
                            err_s   = 1'b1;
                            rdata_s = {BusWidth{1'b0}};
                        end
                    endcase
                end else begin
                    tmo_s = tmo_r + 1'b1;
                end
            end
            RESP: begin
                state_s = IDLE;
                err_s   = 1'b0;
                rdata_s = {BusWidth{1'b0}};
            end
            default: begin
                state_s = IDLE;
                err_s   = 1'b0;
                rdata_s = {BusWidth{1'b0}};
            end
        endcase
    end

    // State, counters, captured access and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            tmo_r   <= {TmoW{1'b0}};
            retry_r <= {RetryW{1'b0}};
            addr_r  <= {BusWidth{1'b0}};
            we_r    <= 1'b0;
            be_r    <= {(BusWidth/8){1'b0}};
            wdata_r <= {BusWidth{1'b0}};
            rdata_r <= {BusWidth{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            tmo_r   <= tmo_s;
            retry_r <= retry_s;
            addr_r  <= addr_s;
            we_r    <= we_s;
            be_r    <= be_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
        end
    end

endmodule

// File: tb/tb_dm_dmi_bridge.sv
// Directed self-checking bench for dm_dmi_bridge (BusWidth 32,
// MaxRetries 4, TimeoutCycles 16). Inputs change and outputs are sampled
// 3 time units after each rising clock edge.
module tb_dm_dmi_bridge;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we, gnt, r_valid, r_err;
    logic [31:0]   addr, wdata, r_rdata;
    logic [3:0]    be;
    logic          dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
    logic          dmi_rst_n;
    dm::dmi_req_t  dmi_req;
    dm::dmi_resp_t dmi_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_dmi_bridge #(
        .BusWidth(32), .MaxRetries(4), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_err_o(r_err),
        .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
        .dmi_req_o(dmi_req),
        .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
        .dmi_resp_i(dmi_resp),
        .dmi_rst_no(dmi_rst_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the sample point of the next cycle.
    task automatic nxt();
        @(posedge clk);
        #3;
    endtask

    // Present an access in IDLE, check the grant, and move to the next cycle.
    task automatic grant(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        chk("gnt_idle", gnt, 1'b1);
        nxt();
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ill_we [3];
        logic [31:0] ill_addr [3];
        logic [3:0]  ill_be [3];
        ill_we   = '{1'b1, 1'b0, 1'b0};
        ill_addr = '{32'h40, 32'h42, 32'h200};
        ill_be   = '{4'h3, 4'hF, 4'hF};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
        dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp = '0;
        nxt(); nxt();
        chk("rst_gnt", gnt, 1'b0);
        chk("rst_rvalid", r_valid, 1'b0);
        chk("rst_rerr", r_err, 1'b0);
        chk("rst_rdata", r_rdata, 32'h0);
        chk("rst_reqvalid", dmi_req_valid, 1'b0);
        chk("rst_respready", dmi_resp_ready, 1'b0);
        chk("rst_dmirstn", dmi_rst_n, 1'b1);
        rst = 1'b0;
        nxt();

        // Read 0x44, immediate ready, success response one cycle later.
        grant(1'b0, 32'h44, 4'hF, 32'h0);
        chk("rd_reqvalid", dmi_req_valid, 1'b1);
        chk("rd_addr", dmi_req.addr, 7'h11);
        chk("rd_op", dmi_req.op, 2'd1);
        chk("rd_data", dmi_req.data, 32'h0);
        dmi_req_ready = 1'b1;
        nxt();
        dmi_req_ready = 1'b0;
        chk("rd_wait_reqvalid", dmi_req_valid, 1'b0);
        chk("rd_wait_respready", dmi_resp_ready, 1'b1);
        dmi_resp_valid = 1'b1; dmi_resp.data = 32'h3; dmi_resp.resp = dm::DTM_SUCCESS;
        nxt();
        dmi_resp_valid = 1'b0;
        chk("rd_rvalid", r_valid, 1'b1);
        chk("rd_rdata", r_rdata, 32'h3);
        chk("rd_rerr", r_err, 1'b0);
        chk("rd_resp_respready", dmi_resp_ready, 1'b0);
        nxt();
        chk("rd_rvalid_once", r_valid, 1'b0);

        // Write 0x40 with one stall cycle; response data must not leak through.
        grant(1'b1, 32'h40, 4'hF, 32'h8000_0001);
        chk("wr_addr", dmi_req.addr, 7'h10);
        chk("wr_op", dmi_req.op, 2'd2);
        chk("wr_data", dmi_req.data, 32'h8000_0001);
        req = 1'b1;
        #1;
        chk("wr_busy_gnt", gnt, 1'b0);
        req = 1'b0;
        nxt();
        chk("wr_stall_reqvalid", dmi_req_valid, 1'b1);
        chk("wr_stall_data", dmi_req.data, 32'h8000_0001);
        dmi_req_ready = 1'b1;
        nxt();
        dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b1; dmi_resp.data = 32'hDEAD_BEEF; dmi_resp.resp = dm::DTM_SUCCESS;
        nxt();
        dmi_resp_valid = 1'b0;
        chk("wr_rvalid", r_valid, 1'b1);
        chk("wr_rerr", r_err, 1'b0);
        chk("wr_rdata", r_rdata, 32'h0);
        nxt();

        // Illegal accesses: partial write, misaligned, out of range.
        for (int i = 0; i < 3; i++) begin
            grant(ill_we[i], ill_addr[i], ill_be[i], 32'h1234_5678);
            chk("ill_rvalid", r_valid, 1'b1);
            chk("ill_rerr", r_err, 1'b1);
            chk("ill_rdata", r_rdata, 32'h0);
            chk("ill_reqvalid", dmi_req_valid, 1'b0);
            req = 1'b1;
            #1;
            chk("ill_resp_gnt", gnt, 1'b0);
            req = 1'b0;
            nxt();
            chk("ill_rvalid_once", r_valid, 1'b0);
            chk("ill_reqvalid_after", dmi_req_valid, 1'b0);
        end

        // BUSY five times: five requests then an error.
        grant(1'b0, 32'h8, 4'hF, 32'h0);
        for (int k = 0; k < 5; k++) begin
            chk("busy_reqvalid", dmi_req_valid, 1'b1);
            chk("busy_addr", dmi_req.addr, 7'h02);
            dmi_req_ready = 1'b1;
            nxt();
            dmi_req_ready = 1'b0;
            chk("busy_respready", dmi_resp_ready, 1'b1);
            dmi_resp_valid = 1'b1; dmi_resp.data = 32'h0; dmi_resp.resp = dm::DTM_BUSY;
            nxt();
            dmi_resp_valid = 1'b0;
        end
        chk("busy_rvalid", r_valid, 1'b1);
        chk("busy_rerr", r_err, 1'b1);
        chk("busy_reqvalid_end", dmi_req_valid, 1'b0);
        nxt();

        // BUSY twice then SUCCESS: three requests, no error.
        grant(1'b0, 32'hC, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("retry_reqvalid", dmi_req_valid, 1'b1);
            dmi_req_ready = 1'b1;
            nxt();
            dmi_req_ready = 1'b0;
            dmi_resp_valid = 1'b1;
            dmi_resp.data = 32'h55;
            dmi_resp.resp = (k < 2) ? dm::DTM_BUSY : dm::DTM_SUCCESS;
            nxt();
            dmi_resp_valid = 1'b0;
        end
        chk("retry_rvalid", r_valid, 1'b1);
        chk("retry_rerr", r_err, 1'b0);
        chk("retry_rdata", r_rdata, 32'h55);
        nxt();

        // Timeout in REQ: ready never comes.
        grant(1'b0, 32'h4, 4'hF, 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk("tmo_reqvalid", dmi_req_valid, 1'b1);
            chk("tmo_dmirstn", dmi_rst_n, (i == 15) ? 1'b0 : 1'b1);
            nxt();
        end
        chk("tmo_rvalid", r_valid, 1'b1);
        chk("tmo_rerr", r_err, 1'b1);
        chk("tmo_dmirstn_after", dmi_rst_n, 1'b1);
        chk("tmo_reqvalid_after", dmi_req_valid, 1'b0);
        nxt();

        // Timeout in WAIT_RESP beats a same-cycle successful response.
        grant(1'b0, 32'h4, 4'hF, 32'h0);
        dmi_req_ready = 1'b1;
        nxt();
        dmi_req_ready = 1'b0;
        for (int i = 1; i < 15; i++) begin
            chk("tmo2_respready", dmi_resp_ready, 1'b1);
            nxt();
        end
        chk("tmo2_dmirstn", dmi_rst_n, 1'b0);
        dmi_resp_valid = 1'b1; dmi_resp.data = 32'h7; dmi_resp.resp = dm::DTM_SUCCESS;
        nxt();
        dmi_resp_valid = 1'b0;
        chk("tmo2_rvalid", r_valid, 1'b1);
        chk("tmo2_rerr", r_err, 1'b1);
        chk("tmo2_rdata", r_rdata, 32'h0);
        nxt();

        // Normal read after the timeouts.
        grant(1'b0, 32'h44, 4'hF, 32'h0);
        dmi_req_ready = 1'b1;
        nxt();
        dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b1; dmi_resp.data = 32'h9; dmi_resp.resp = dm::DTM_SUCCESS;
        nxt();
        dmi_resp_valid = 1'b0;
        chk("post_rvalid", r_valid, 1'b1);
        chk("post_rdata", r_rdata, 32'h9);
        chk("post_rerr", r_err, 1'b0);
        nxt();

        // Reset while waiting for the response; the late response is ignored.
        grant(1'b0, 32'h44, 4'hF, 32'h0);
        dmi_req_ready = 1'b1;
        nxt();
        dmi_req_ready = 1'b0;
        chk("mid_respready", dmi_resp_ready, 1'b1);
        rst = 1'b1;
        dmi_resp_valid = 1'b1; dmi_resp.data = 32'hAA; dmi_resp.resp = dm::DTM_SUCCESS;
        nxt();
        rst = 1'b0;
        chk("mid_rvalid", r_valid, 1'b0);
        chk("mid_respready_rst", dmi_resp_ready, 1'b0);
        chk("mid_reqvalid", dmi_req_valid, 1'b0);
        chk("mid_rerr", r_err, 1'b0);
        chk("mid_rdata", r_rdata, 32'h0);
        chk("mid_dmirstn", dmi_rst_n, 1'b1);
        nxt();
        chk("mid_rvalid_later", r_valid, 1'b0);
        chk("mid_respready_later", dmi_resp_ready, 1'b0);
        dmi_resp_valid = 1'b0;
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
